// File: rtl/decode_control_pipe.sv
// decode_control_pipe: registered decode/control stage for the stack machine.
// One-entry output register with valid/ready on both sides, stack occupancy
// tracking with underflow/overflow detection before issue, and a small FSM
// that stalls intake while a data-memory access completes or a fault is pending.
module decode_control_pipe #(
  parameter int INSTR_W     = 32,
  parameter int STACK_DEPTH = 16,
  parameter int CNT_W       = 5,
  parameter int MEM_LAT     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               ALUOp,
  output logic [1:0]         PCSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         StackWriteSrc,
  output logic               ALUSrc,
  output logic [1:0]         StackUpdateMode,
  output logic [INSTR_W-7:0] imm,
  output logic [CNT_W-1:0]   stack_count,
  output logic               fault,
  output logic [1:0]         fault_code,
  input  logic               fault_clear
);

  // Stall counter sized for MEM_LAT-1; at least one bit even when the stall is off.
  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam logic [LAT_W-1:0] LAT_LOAD = (MEM_LAT > 0) ? LAT_W'(MEM_LAT - 1) : '0;
  localparam logic LAT_EN = (MEM_LAT > 0) ? 1'b1 : 1'b0;
  localparam logic signed [CNT_W+1:0] DEPTH_S = (CNT_W+2)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

  typedef struct packed {
    logic       alu_op;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] wsrc;
    logic       alu_src;
    logic [1:0] mode;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]        need;
    logic signed [2:0] net;
    ctrl_t             ctrl;
  } dec_t;

  // Decode one instruction into stack requirement, net stack change and control fields.
  function automatic dec_t decode(input logic [2:0] op1, input logic [2:0] op2);
    dec_t d;
    d = '0;
    case (op1)
      3'b000: begin
        d.ctrl.wsrc = 2'b01;
        if (op2 == 3'b010 || op2 == 3'b111) begin
          d.need = 2'd1; d.net = 3'sb000; d.ctrl.mode = 2'b00;
        end else begin
          d.need = 2'd2; d.net = 3'sb111; d.ctrl.mode = 2'b11;
        end
      end
      3'b001: begin
        d.ctrl.alu_src = 1'b1;
        d.ctrl.wsrc    = 2'b01;
        if (op2 == 3'b111) begin
          d.need = 2'd0; d.net = 3'sb001; d.ctrl.mode = 2'b01;
        end else begin
          d.need = 2'd1; d.net = 3'sb000; d.ctrl.mode = 2'b00;
        end
      end
      3'b010: begin
        d.need = 2'd0; d.net = 3'sb001;
        d.ctrl.mem_read = 1'b1; d.ctrl.wsrc = 2'b10; d.ctrl.mode = 2'b01;
      end
      3'b011: begin
        d.need = 2'd1; d.net = 3'sb111;
        d.ctrl.mem_write = 1'b1; d.ctrl.wsrc = 2'b00; d.ctrl.mode = 2'b11;
      end
      3'b100: begin
        d.need = 2'd2; d.net = 3'sb111;
        d.ctrl.alu_op = 1'b1; d.ctrl.wsrc = 2'b01; d.ctrl.mode = 2'b11;
      end
      3'b101: begin
        d.need = 2'd2; d.net = 3'sb110;
        d.ctrl.alu_op = 1'b1; d.ctrl.pc_src = 2'b01; d.ctrl.wsrc = 2'b00; d.ctrl.mode = 2'b10;
      end
      3'b110: begin
        d.need = 2'd0; d.net = 3'sb001;
        d.ctrl.wsrc = 2'b11; d.ctrl.mode = 2'b01;
      end
      3'b111: begin
        d.need = 2'd1; d.net = 3'sb111;
        d.ctrl.pc_src = 2'b10; d.ctrl.wsrc = 2'b00; d.ctrl.mode = 2'b11;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t             state_q;
  logic [LAT_W-1:0]   wait_q;
  ctrl_t              ctrl_q;
  logic [INSTR_W-7:0] imm_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               fault_q;
  logic [1:0]         fault_code_q;

  dec_t                     dec_s;
  logic                     ready_s;
  logic                     accept_s;
  logic                     under_s;
  logic                     over_s;
  logic                     load_s;
  logic                     mem_s;
  logic signed [CNT_W+1:0]  sum_s;

  // Decode the offered instruction and evaluate accept and fault conditions.
  always_comb begin
    dec_s    = decode(instruction[INSTR_W-1:INSTR_W-3], instruction[INSTR_W-4:INSTR_W-6]);
    ready_s  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    accept_s = in_valid && ready_s;
    sum_s    = $signed({2'b00, count_q}) + $signed({{(CNT_W-1){dec_s.net[2]}}, dec_s.net});
    under_s  = (count_q < CNT_W'(dec_s.need));
    if (under_s) begin
      over_s = 1'b0;
    end else begin
      over_s = (sum_s > DEPTH_S);
    end
    load_s  = accept_s && !under_s && !over_s;
    mem_s   = dec_s.ctrl.mem_read || dec_s.ctrl.mem_write;
    count_d = sum_s[CNT_W-1:0];
  end

  // Output register, occupancy counter and RUN/MEM_WAIT/FAULT state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      ctrl_q       <= '0;
      imm_q        <= '0;
      out_valid_q  <= 1'b0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      if (load_s) begin
        ctrl_q      <= dec_s.ctrl;
        imm_q       <= instruction[INSTR_W-7:0];
        out_valid_q <= 1'b1;
        count_q     <= count_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end

      case (state_q)
        ST_RUN: begin
          if (accept_s && under_s) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b01;
          end else if (accept_s && over_s) begin
            state_q      <= ST_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b10;
          end else if (load_s && mem_s && LAT_EN) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= LAT_LOAD;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (wait_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            wait_q <= wait_q - LAT_W'(1);
          end
        end
        ST_FAULT: begin
          if (fault_clear) begin
            state_q      <= ST_RUN;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
          end else begin
            state_q <= ST_FAULT;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign in_ready        = ready_s;
  assign out_valid       = out_valid_q;
  assign ALUOp           = ctrl_q.alu_op;
  assign PCSrc           = ctrl_q.pc_src;
  assign MemRead         = ctrl_q.mem_read;
  assign MemWrite        = ctrl_q.mem_write;
  assign StackWriteSrc   = ctrl_q.wsrc;
  assign ALUSrc          = ctrl_q.alu_src;
  assign StackUpdateMode = ctrl_q.mode;
  assign imm             = imm_q;
  assign stack_count     = count_q;
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the stage.
module tb_decode_control_pipe;
  localparam int DEPTH   = 16;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic        ALUOp, MemRead, MemWrite, ALUSrc, fault, fault_clear;
  logic [1:0]  PCSrc, StackWriteSrc, StackUpdateMode, fault_code;
  logic [31:0] instruction;
  logic [25:0] imm;
  logic [4:0]  stack_count;

  decode_control_pipe #(.INSTR_W(32), .STACK_DEPTH(DEPTH), .CNT_W(5), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .StackWriteSrc(StackWriteSrc), .ALUSrc(ALUSrc), .StackUpdateMode(StackUpdateMode),
    .imm(imm), .stack_count(stack_count), .fault(fault), .fault_code(fault_code),
    .fault_clear(fault_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy, busy/fault status, remaining stall cycles, held bundle.
  int         m_count, m_wait, m_code;
  bit         m_ov, m_fault, m_busy_fault;
  logic [9:0] m_f;
  logic [25:0] m_imm;

  localparam logic [31:0] PUSH    = 32'h5C00_0000;
  localparam logic [31:0] ADD     = 32'h0000_0000;
  localparam logic [31:0] NEG     = 32'h0800_0000;
  localparam logic [31:0] POP     = 32'h7C00_0000;
  localparam logic [31:0] PUSH_PC = 32'hDC00_0000;
  localparam logic [31:0] BRANCH  = 32'hA400_0000;
  localparam logic [31:0] POP_PC  = 32'hE000_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec table: need, net, fields; the update mode follows from the net change.
  task automatic ref_decode(input logic [31:0] ins, output int need, output int net,
                            output logic [9:0] f, output bit mem);
    logic [2:0] op1, op2;
    logic alu, mr, mw, as;
    logic [1:0] pcs, ws, md;
    op1 = ins[31:29]; op2 = ins[28:26];
    alu = 0; mr = 0; mw = 0; as = 0; pcs = 0; ws = 0;
    case (op1)
      3'd0: begin ws = 2'b01; if (op2 == 3'd2 || op2 == 3'd7) begin need = 1; net = 0; end
                              else begin need = 2; net = -1; end end
      3'd1: begin ws = 2'b01; as = 1; if (op2 == 3'd7) begin need = 0; net = 1; end
                                      else begin need = 1; net = 0; end end
      3'd2: begin need = 0; net = 1; mr = 1; ws = 2'b10; end
      3'd3: begin need = 1; net = -1; mw = 1; end
      3'd4: begin need = 2; net = -1; alu = 1; ws = 2'b01; end
      3'd5: begin need = 2; net = -2; alu = 1; pcs = 2'b01; end
      3'd6: begin need = 0; net = 1; ws = 2'b11; end
      default: begin need = 1; net = -1; pcs = 2'b10; end
    endcase
    md = (net == 1) ? 2'b01 : (net == 0) ? 2'b00 : (net == -1) ? 2'b11 : 2'b10;
    f = {alu, pcs, mr, mw, ws, as, md};
    mem = mr | mw;
  endtask

  task automatic cyc(input bit iv, input logic [31:0] ins, input bit ordy,
                     input bit fclr, input bit rst);
    bit exp_rdy, acc, nxt_ov, mem;
    int need, net;
    logic [9:0] f;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("fields", 32'({ALUOp, PCSrc, MemRead, MemWrite, StackWriteSrc, ALUSrc, StackUpdateMode}), 32'(m_f));
    check("imm", 32'(imm), 32'(m_imm));
    check("stack_count", 32'(stack_count), 32'(m_count));
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_code", 32'(fault_code), 32'(m_code));
    reset = rst; in_valid = iv; instruction = ins; out_ready = ordy; fault_clear = fclr;
    #1;
    exp_rdy = (m_wait == 0) && !m_busy_fault && (!m_ov || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      m_count = 0; m_wait = 0; m_code = 0; m_ov = 0; m_fault = 0; m_busy_fault = 0;
      m_f = '0; m_imm = '0;
    end else begin
      acc = iv && exp_rdy;
      nxt_ov = m_ov && !ordy;
      if (m_wait > 0) begin
        m_wait--;
      end else if (m_busy_fault) begin
        if (fclr) begin m_busy_fault = 0; m_fault = 0; m_code = 0; end
      end else if (acc) begin
        ref_decode(ins, need, net, f, mem);
        if (m_count < need) begin
          m_fault = 1; m_code = 1; m_busy_fault = 1;
        end else if (m_count + net > DEPTH) begin
          m_fault = 1; m_code = 2; m_busy_fault = 1;
        end else begin
          m_f = f; m_imm = ins[25:0]; nxt_ov = 1; m_count += net;
          if (mem) m_wait = MEM_LAT;
        end
      end
      m_ov = nxt_ov;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 1, 0, 0);
  endtask

  initial begin
    reset = 1; in_valid = 0; instruction = '0; out_ready = 1; fault_clear = 0;
    m_count = 0; m_wait = 0; m_code = 0; m_ov = 0; m_fault = 0; m_busy_fault = 0;
    m_f = '0; m_imm = '0;
    cyc(0, 32'h0, 1, 0, 1);
    cyc(0, 32'h0, 1, 0, 1);

    // Pushes with memory stall after each.
    for (int i = 0; i < 3; i++) begin
      cyc(1, PUSH | 32'(i + 5), 1, 0, 0);
      #2;
      check("plan1_count", 32'(stack_count), 32'(i + 1));
      check("plan1_mode", 32'({MemRead, StackWriteSrc, StackUpdateMode}), 32'b1_10_01);
      idle(2);
    end
    cyc(1, POP, 1, 0, 0); idle(2);
    cyc(1, ADD, 1, 0, 0);
    #2; check("plan2_add", 32'({ALUOp, StackWriteSrc, StackUpdateMode, stack_count}), {23'd0, 9'b0_01_11_00001});
    cyc(1, NEG, 1, 0, 0);
    #2; check("plan2_neg", 32'({StackUpdateMode, stack_count}), 32'b00_00001);

    // Underflow from empty stack, then acknowledge.
    cyc(0, 32'h0, 1, 0, 1);
    cyc(1, POP, 1, 0, 0);
    #2; check("plan3_fault", 32'({fault, fault_code, out_valid, in_ready}), 32'b1_01_0_0);
    idle(2);
    cyc(0, 32'h0, 1, 1, 0);
    #2; check("plan3_clear", 32'({fault, in_ready, stack_count}), 32'b0_1_00000);

    // Fill to depth, then overflow.
    for (int i = 0; i < 16; i++) cyc(1, PUSH_PC | 32'(i), 1, 0, 0);
    #2; check("plan4_full", 32'(stack_count), 32'd16);
    cyc(1, PUSH_PC, 1, 0, 0);
    #2; check("plan4_over", 32'({fault_code, stack_count}), 32'b10_10000);
    cyc(0, 32'h0, 1, 1, 0);

    // Back-pressure hold, then release with no bubble.
    cyc(1, ADD | 32'h123, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, NEG | 32'h77, 0, 0, 0);
    cyc(1, NEG | 32'h77, 1, 0, 0);
    #2; check("plan5_nobubble", 32'({out_valid, imm}), {5'd0, 1'b1, 26'h77});
    idle(1);

    // Branch, pop_pc, reset during a memory stall.
    cyc(0, 32'h0, 1, 0, 1);
    cyc(1, PUSH_PC, 1, 0, 0); cyc(1, PUSH_PC, 1, 0, 0);
    cyc(1, BRANCH, 1, 0, 0);
    #2; check("plan6_branch", 32'({PCSrc, StackUpdateMode, ALUOp, stack_count}), 32'b01_10_1_00000);
    cyc(1, PUSH_PC, 1, 0, 0);
    cyc(1, POP_PC, 1, 0, 0);
    #2; check("plan6_poppc", 32'({PCSrc, stack_count}), 32'b10_00000);
    cyc(1, PUSH, 1, 0, 0);
    cyc(0, 32'h0, 0, 0, 1);
    #2; check("plan6_reset", 32'({out_valid, ALUOp, PCSrc, MemRead, MemWrite, StackWriteSrc,
                                  ALUSrc, StackUpdateMode, stack_count, fault, fault_code, in_ready}),
              32'b0_0_00_0_0_00_0_00_00000_0_00_1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_control_pipe.md
Name: decode_control_pipe

Overview:
Registered, stack-aware decode/control stage for the stack-machine datapath. It replaces the purely combinational decoder with a one-entry output register and valid/ready handshakes on both sides. It tracks stack occupancy and raises underflow/overflow faults before an instruction issues. A small FSM stalls intake while a data-memory access completes.

Parameters:
INSTR_W, 32, instruction width; opcode1 = instruction[INSTR_W-1:INSTR_W-3], opcode2 = instruction[INSTR_W-4:INSTR_W-6]
STACK_DEPTH, 16, maximum number of stack entries
CNT_W, 5, stack_count width; must satisfy 2^CNT_W > STACK_DEPTH
MEM_LAT, 2, stall cycles after issuing a MemRead or MemWrite instruction; 0 disables the stall

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  stage accepts the instruction this cycle
instruction  in  INSTR_W  instruction word
out_valid  out  1  control bundle valid
out_ready  in  1  downstream consumes the bundle
ALUOp  out  1  0: ALU, 1: comparator
PCSrc  out  2  00: PC+1, 01: branch, 10: pop_pc
MemRead  out  1  data-memory read
MemWrite  out  1  data-memory write
StackWriteSrc  out  2  00: none, 01: ALU result, 10: dmem read, 11: PC+1
ALUSrc  out  1  0: stack, 1: immediate
StackUpdateMode  out  2  00: sp, 01: sp+1, 10: sp-2, 11: sp-1
imm  out  INSTR_W-6  registered instruction[INSTR_W-7:0]
stack_count  out  CNT_W  current stack occupancy
fault  out  1  sticky fault flag
fault_code  out  2  01: underflow, 10: overflow
fault_clear  in  1  one-cycle fault acknowledge

Behaviour:
- Reset: all outputs 0, state RUN, stack_count 0, MEM_WAIT counter 0. in_ready is 1 in the first cycle after reset. Reset overrides every state, including mid-MEM_WAIT and FAULT.
- Decode table (opcode1: need / net / fields):
  - 000 ALU: unary when opcode2 is 010 or 111 (need 1, net 0, mode 00); otherwise need 2, net -1, mode 11. ALUOp 0, ALUSrc 0, WriteSrc 01.
  - 001 ALU-immediate: opcode2 111 (noti) has need 0, net +1, mode 01; otherwise need 1, net 0, mode 00. ALUSrc 1, WriteSrc 01.
  - 010 push: need 0, net +1, MemRead 1, WriteSrc 10, mode 01.
  - 011 pop: need 1, net -1, MemWrite 1, WriteSrc 00, mode 11.
  - 100 compare: need 2, net -1, ALUOp 1, WriteSrc 01, mode 11.
  - 101 branch: need 2, net -2, ALUOp 1, PCSrc 01, WriteSrc 00, mode 10.
  - 110 push_pc: need 0, net +1, WriteSrc 11, mode 01.
  - 111 pop_pc: need 1, net -1, PCSrc 10, WriteSrc 00, mode 11.
  - Any field not listed is 0. opcode2 is ignored except in groups 000 and 001.
- in_ready = (state==RUN) && (!out_valid || out_ready). An instruction is accepted when in_valid && in_ready.
- Accept with no fault:
  - Next edge loads the bundle and imm, sets out_valid=1, and updates stack_count by net.
  - If MemRead|MemWrite and MEM_LAT>0, state goes to MEM_WAIT for exactly MEM_LAT cycles, then back to RUN.
- Latency is one cycle from accept to out_valid. Drain and load in the same cycle (out_ready=1, new accept) are a legal back-to-back issue.
- Fault check at accept:
  - Underflow: stack_count < need.
  - Overflow: stack_count + net > STACK_DEPTH.
  - On fault: the instruction is dropped and the output register is not loaded (an existing bundle still drains normally). stack_count is unchanged, fault=1, fault_code is set, state goes to FAULT.
  - Underflow and overflow are mutually exclusive by construction.
- FAULT: in_ready=0. fault_clear for one cycle gives fault=0, fault_code=00 and state RUN on the next edge. fault_clear is ignored outside FAULT.
- While out_valid && !out_ready, the bundle, imm and stack_count are held stable.
- MEM_WAIT: in_ready=0; the output register may drain.
- stack_count never wraps; the only way to reach 0 or STACK_DEPTH is a legal net update.

Test Plan:
1. Reset, MEM_LAT=2, out_ready=1, push (0x5C000000) three times -> stack_count 1,2,3; MemRead=1, WriteSrc 10, mode 01; in_ready low for 2 cycles after each accept.
2. At count 2, add (0x00000000) -> ALUOp 0, WriteSrc 01, mode 11, count 1. neg (0x08000000) -> mode 00, count unchanged.
3. After reset, pop (0x7C000000) -> fault=1, code 01, out_valid stays 0, in_ready 0. Pulse fault_clear -> fault 0, in_ready 1, count 0.
4. push_pc (0xDC000000) ×16 -> count 16. 17th -> overflow code 10, count stays 16.
5. Hold out_ready=0 with out_valid=1 -> in_ready 0 and outputs stable for 5 cycles. Raise out_ready with in_valid=1 -> new bundle the next cycle, no bubble.
6. At count 2, branch (0xA4000000) -> PCSrc 01, mode 10, ALUOp 1, count 0. Then pop_pc at count 1 -> PCSrc 10, count 0. Assert reset during MEM_WAIT -> all outputs 0 next cycle.
